phasediff_seq: RTL and testbench
================================

# phasediff_seq

Sequencer that time-shares one `phasediff` unit across the four hydrophone phase channels of the USBL array. It latches a 4-channel phase snapshot and issues the three baseline pairs (ch1−ch0, ch2−ch0, ch3−ch0) to `phasediff` one at a time. It collects each result and presents all three differences together with a one-cycle valid strobe. It sits between the per-channel phase estimators and the angle-of-arrival stage.

## Interface
- `PW`, 19: phase word width (Q9.10 degrees, same format as `phasediff`).
- `DIFF_LAT`, 1: `phasediff` latency in cycles, from the `data_rdy` cycle to `out` being valid. Legal range is 1..15.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `ph_valid` in 1: snapshot strobe. Phases are accepted when it is high and `ph_ready` is high.
- `ph0`, `ph1`, `ph2`, `ph3` in PW each: channel phases.
- `ph_ready` out 1: high only in state IDLE.
- `pd_data_rdy` out 1: drives `phasediff.data_rdy`.
- `pd_phase1` out PW: drives `phasediff.in_phase1`.
- `pd_phase2` out PW: drives `phasediff.in_phase2`.
- `pd_out` in PW: from `phasediff.out`.
- `diff10`, `diff20`, `diff30` out PW each: captured differences. They hold their value until the next DONE.
- `diff_valid` out 1: one-cycle pulse, high in the cycle the diff outputs first show new values.
- `ovr` out 1: sticky overrun flag. Cleared only by `reset`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. State, 2-bit pair index `idx` and 4-bit latency counter `cnt` are all registered.
- IDLE:
  - `ph_ready`=1.
  - On `ph_valid`: latch `ph0`..`ph3` into snapshot registers, set `idx`=0, go to ISSUE.
- ISSUE (one cycle):
  - `pd_data_rdy`=1.
  - `pd_phase1`/`pd_phase2` = (ph1,ph0), (ph2,ph0), (ph3,ph0) for `idx`=0,1,2.
  - Load `cnt`=DIFF_LAT, go to WAIT.
- WAIT:
  - `pd_data_rdy`=0. `pd_phase1`/`pd_phase2` hold their value.
  - `cnt` decrements each cycle.
  - In the cycle where `cnt`==1, capture `pd_out` into the working register selected by `idx`.
  - Then: if `idx`<2, increment `idx` and go to ISSUE; else go to DONE.
- DONE (one cycle):
  - Copy the three working registers to `diff10`/`diff20`/`diff30` on entry, so outputs change atomically.
  - `diff_valid`=1, then go to IDLE.
- No arithmetic is done in this block. Wrap-around and sign are handled entirely by `phasediff`. Captured values are stored bit-exact.
- `pd_phase1`/`pd_phase2`/`pd_data_rdy` are registered outputs, set on the edge that enters ISSUE.
- Overrun: `ph_valid`=1 in any state other than IDLE sets `ovr`=1. That snapshot is dropped and the in-flight frame is unaffected. This includes `ph_valid` arriving in DONE.
- Reset values:
  - state=IDLE, so `ph_ready`=1 while reset is asserted.
  - `pd_data_rdy`=0, `pd_phase1`=`pd_phase2`=0.
  - `diff10`=`diff20`=`diff30`=0, `diff_valid`=0, `ovr`=0.
  - Snapshot, working registers, `idx` and `cnt` = 0.
- Reset mid-frame: the frame is abandoned immediately. No `diff_valid` is produced and outputs return to their reset values.

## Timing
- Take acceptance as cycle 0 (edge at end of cycle 0, with `ph_valid`·`ph_ready`).
- Pair k is in ISSUE in cycle 1+k·(1+DIFF_LAT).
- `pd_out` for pair k is sampled on the edge ending cycle 1+k·(1+DIFF_LAT)+DIFF_LAT.
- DONE / `diff_valid` high in cycle 3·(1+DIFF_LAT)+1. For DIFF_LAT=1 this is cycle 7.
- `ph_ready` is back high in cycle 3·(1+DIFF_LAT)+2. Sustained throughput is one frame per 3·DIFF_LAT+5 cycles.
- `pd_data_rdy` is never high in two consecutive cycles, and never high outside ISSUE.
- `diff_valid` is exactly one cycle wide. `diff*` outputs are stable from DONE until the next DONE.

## Test plan
- **Basic frame.** Bench uses a behavioural `phasediff` model returning (in_phase1−in_phase2) mod 2^19 with DIFF_LAT=1.
  - Stimulus: ph0=0x04000, ph1=0x08000, ph2=0x2D000, ph3=0x00000, one-cycle `ph_valid`.
  - Required: diff10=0x04000, diff20=0x29000, diff30=0x7C000, with `diff_valid` in cycle 7 and `ph_ready` in cycle 8.
- **Pair ordering.** Check `pd_phase1`/`pd_phase2` during each `pd_data_rdy` pulse: (0x08000,0x04000), (0x2D000,0x04000), (0x00000,0x04000), with pulses in cycles 1, 3, 5.
- **Latency parameter.** With DIFF_LAT=4 and the model delayed to match:
  - Same values as the basic frame are required.
  - `diff_valid` in cycle 16.
  - ISSUE in cycles 1, 6, 11.
- **Overrun.**
  - `ph_valid` in cycle 3 of a frame: `ovr` rises at cycle 4 and the first frame's results are unchanged.
  - A new frame with ph0..ph3=0x2D000 is accepted in cycle 8 and gives all diffs = 0 with `ovr` still 1.
- **Reset mid-frame.**
  - `reset` asserted in cycle 4 (asynchronously, mid-cycle): all outputs go to reset values immediately, no `diff_valid` occurs, and `ph_ready`=1.
  - After release, a fresh frame completes normally.
- **Back-to-back.**
  - `ph_valid` held high continuously with changing data: frames are accepted only in IDLE cycles (one per 8 cycles for DIFF_LAT=1).
  - Each `diff_valid` matches its own snapshot.
  - `ovr`=1 from the second cycle of `ph_valid` onward.

Source files
------------

// File: rtl/phasediff_seq_if.sv
// phasediff_seq_if: snapshot input, phasediff unit link and result outputs of phasediff_seq
interface phasediff_seq_if #(parameter int PW = 19);
  logic ph_valid, ph_ready, pd_data_rdy, diff_valid, ovr;
  logic [PW-1:0] ph0, ph1, ph2, ph3, pd_phase1, pd_phase2, pd_out, diff10, diff20, diff30;
  modport master (
    output ph_valid, ph0, ph1, ph2, ph3, pd_out,
    input ph_ready, pd_data_rdy, pd_phase1, pd_phase2, diff10, diff20, diff30, diff_valid, ovr
  );
  modport slave (
    input ph_valid, ph0, ph1, ph2, ph3, pd_out,
    output ph_ready, pd_data_rdy, pd_phase1, pd_phase2, diff10, diff20, diff30, diff_valid, ovr
  );
endinterface

// File: rtl/phasediff_seq.sv
// phasediff_seq: time-shares one phasediff unit over baselines ch1-ch0, ch2-ch0, ch3-ch0
module phasediff_seq #(
  parameter int PW = 19,
  parameter int DIFF_LAT = 1
) (
  input logic clk,
  input logic reset,
  phasediff_seq_if.slave io
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [PW-1:0] s0_q, s0_d, s2_q, s2_d, s3_q, s3_d, w0_q, w0_d, w1_q, w1_d;
  logic [PW-1:0] p1_q, p1_d, p2_q, p2_d, d10_q, d10_d, d20_q, d20_d, d30_q, d30_d;
  logic rdy_q, rdy_d, dv_q, dv_d, ovr_q, ovr_d, cap;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    s0_d = s0_q;
    s2_d = s2_q;
    s3_d = s3_q;
    w0_d = w0_q;
    w1_d = w1_q;
    p1_d = p1_q;
    p2_d = p2_q;
    d10_d = d10_q;
    d20_d = d20_q;
    d30_d = d30_q;
    rdy_d = 1'b0;
    dv_d = 1'b0;
    ovr_d = ovr_q | (io.ph_valid & (state_q != IDLE));
    cap = (state_q == WAIT) && (cnt_q == 4'd1);
    case (state_q)
      IDLE: if (io.ph_valid) begin
        s0_d = io.ph0;
        s2_d = io.ph2;
        s3_d = io.ph3;
        idx_d = 2'd0;
        p1_d = io.ph1;
        p2_d = io.ph0;
        rdy_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d = 4'(DIFF_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cap) begin
          w0_d = idx_q == 2'd0 ? io.pd_out : w0_q;
          w1_d = idx_q == 2'd1 ? io.pd_out : w1_q;
          if (idx_q != 2'd2) begin
            idx_d = idx_q + 2'd1;
            p1_d = idx_q == 2'd0 ? s2_q : s3_q;
            p2_d = s0_q;
            rdy_d = 1'b1;
            state_d = ISSUE;
          end else begin
            // last pair goes straight to the outputs so all three change on the same edge
            d10_d = w0_q;
            d20_d = w1_q;
            d30_d = io.pd_out;
            dv_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      s0_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      w0_q <= '0;
      w1_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      d10_q <= '0;
      d20_q <= '0;
      d30_q <= '0;
      rdy_q <= 1'b0;
      dv_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      s0_q <= s0_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      w0_q <= w0_d;
      w1_q <= w1_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      d10_q <= d10_d;
      d20_q <= d20_d;
      d30_q <= d30_d;
      rdy_q <= rdy_d;
      dv_q <= dv_d;
      ovr_q <= ovr_d;
    end
  end
  assign io.ph_ready = state_q == IDLE;
  assign io.pd_data_rdy = rdy_q;
  assign io.pd_phase1 = p1_q;
  assign io.pd_phase2 = p2_q;
  assign io.diff10 = d10_q;
  assign io.diff20 = d20_q;
  assign io.diff30 = d30_q;
  assign io.diff_valid = dv_q;
  assign io.ovr = ovr_q;
endmodule

// File: tb/tb_phasediff_seq.sv
// tb_phasediff_seq: scoreboard bench with DIFF_LAT=1 and DIFF_LAT=4 instances and a behavioural phasediff
module tb_phasediff_seq;
  localparam int PW = 19;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [3*PW-1:0] qa[$], qb[$];
  logic [PW-1:0] pa;
  logic [PW-1:0] pb[4];
  localparam logic [3*PW-1:0] BASIC = {19'h04000, 19'h29000, 19'h7C000};

  phasediff_seq_if #(.PW(PW)) ia();
  phasediff_seq_if #(.PW(PW)) ib();
  phasediff_seq #(.PW(PW), .DIFF_LAT(1)) u_a (.clk(clk), .reset(reset), .io(ia));
  phasediff_seq #(.PW(PW), .DIFF_LAT(4)) u_b (.clk(clk), .reset(reset), .io(ib));

  always #5 clk = ~clk;

  // behavioural phasediff: result DIFF_LAT cycles after data_rdy, zero otherwise
  always @(posedge clk) pa <= ia.pd_data_rdy ? PW'(ia.pd_phase1 - ia.pd_phase2) : '0;
  always @(posedge clk) begin
    pb[0] <= ib.pd_data_rdy ? PW'(ib.pd_phase1 - ib.pd_phase2) : '0;
    for (int i = 1; i < 4; i++) pb[i] <= pb[i-1];
  end
  assign ia.pd_out = pa;
  assign ib.pd_out = pb[3];

  function automatic logic [3*PW-1:0] expd(input logic [PW-1:0] p0, p1, p2, p3);
    return {PW'(p1 - p0), PW'(p2 - p0), PW'(p3 - p0)};
  endfunction

  task automatic start_a(input logic [PW-1:0] p0, p1, p2, p3);
    ia.ph0 = p0; ia.ph1 = p1; ia.ph2 = p2; ia.ph3 = p3; ia.ph_valid = 1'b1;
    qa.push_back(expd(p0, p1, p2, p3));
  endtask

  task automatic start_b(input logic [PW-1:0] p0, p1, p2, p3);
    ib.ph0 = p0; ib.ph1 = p1; ib.ph2 = p2; ib.ph3 = p3; ib.ph_valid = 1'b1;
    qb.push_back(expd(p0, p1, p2, p3));
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ia.ph_ready !== 1'b1) begin errors++; $display("FAIL reset_ph_ready got %b exp 1", ia.ph_ready); end
    checks++; if (ia.pd_data_rdy !== 1'b0) begin errors++; $display("FAIL reset_pd_data_rdy got %b exp 0", ia.pd_data_rdy); end
    checks++; if ({ia.pd_phase1, ia.pd_phase2} !== '0) begin errors++; $display("FAIL reset_pd_phase got %h %h exp 0", ia.pd_phase1, ia.pd_phase2); end
    checks++; if ({ia.diff10, ia.diff20, ia.diff30} !== '0) begin errors++; $display("FAIL reset_diffs got %h %h %h exp 0", ia.diff10, ia.diff20, ia.diff30); end
    checks++; if ({ia.diff_valid, ia.ovr} !== 2'b00) begin errors++; $display("FAIL reset_valid_ovr got %b%b exp 00", ia.diff_valid, ia.ovr); end
    checks++; if (ib.ph_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ph_ready got %b exp 1", ib.ph_ready); end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [PW-1:0] e1[3] = '{19'h08000, 19'h2D000, 19'h00000};
    logic [3*PW-1:0] e;
    @(negedge clk);
    start_a(19'h04000, 19'h08000, 19'h2D000, 19'h00000);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      ia.ph_valid = 1'b0;
      checks++; if (ia.pd_data_rdy !== (c == 1 || c == 3 || c == 5)) begin errors++; $display("FAIL basic_pd_data_rdy cycle %0d got %b", c, ia.pd_data_rdy); end
      if (c == 1 || c == 3 || c == 5) begin
        checks++; if (ia.pd_phase1 !== e1[c/2] || ia.pd_phase2 !== 19'h04000) begin errors++; $display("FAIL basic_pair cycle %0d got %h,%h exp %h,04000", c, ia.pd_phase1, ia.pd_phase2, e1[c/2]); end
      end
      if (c == 2) begin
        checks++; if (ia.pd_phase1 !== 19'h08000) begin errors++; $display("FAIL basic_pair_hold got %h exp 08000", ia.pd_phase1); end
      end
      checks++; if (ia.diff_valid !== (c == 7)) begin errors++; $display("FAIL basic_diff_valid cycle %0d got %b", c, ia.diff_valid); end
      checks++; if (ia.ph_ready !== (c == 8)) begin errors++; $display("FAIL basic_ph_ready cycle %0d got %b", c, ia.ph_ready); end
      if (c == 7) begin
        e = qa.size() != 0 ? qa.pop_front() : 'x;
        checks++; if ({ia.diff10, ia.diff20, ia.diff30} !== e) begin errors++; $display("FAIL basic_sb got %h %h %h exp %h", ia.diff10, ia.diff20, ia.diff30, e); end
        checks++; if ({ia.diff10, ia.diff20, ia.diff30} !== BASIC) begin errors++; $display("FAIL basic_values got %h %h %h exp 04000 29000 7c000", ia.diff10, ia.diff20, ia.diff30); end
      end
    end
  endtask

  task automatic test_latency;
    logic [PW-1:0] e1[3] = '{19'h08000, 19'h2D000, 19'h00000};
    logic [3*PW-1:0] e;
    @(negedge clk);
    start_b(19'h04000, 19'h08000, 19'h2D000, 19'h00000);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      ib.ph_valid = 1'b0;
      checks++; if (ib.pd_data_rdy !== (c == 1 || c == 6 || c == 11)) begin errors++; $display("FAIL lat_pd_data_rdy cycle %0d got %b", c, ib.pd_data_rdy); end
      if (c == 1 || c == 6 || c == 11) begin
        checks++; if (ib.pd_phase1 !== e1[(c-1)/5] || ib.pd_phase2 !== 19'h04000) begin errors++; $display("FAIL lat_pair cycle %0d got %h,%h exp %h,04000", c, ib.pd_phase1, ib.pd_phase2, e1[(c-1)/5]); end
      end
      checks++; if (ib.diff_valid !== (c == 16)) begin errors++; $display("FAIL lat_diff_valid cycle %0d got %b", c, ib.diff_valid); end
      checks++; if (ib.ph_ready !== (c == 17)) begin errors++; $display("FAIL lat_ph_ready cycle %0d got %b", c, ib.ph_ready); end
      if (c == 16) begin
        e = qb.size() != 0 ? qb.pop_front() : 'x;
        checks++; if ({ib.diff10, ib.diff20, ib.diff30} !== e) begin errors++; $display("FAIL lat_sb got %h %h %h exp %h", ib.diff10, ib.diff20, ib.diff30, e); end
        checks++; if ({ib.diff10, ib.diff20, ib.diff30} !== BASIC) begin errors++; $display("FAIL lat_values got %h %h %h exp 04000 29000 7c000", ib.diff10, ib.diff20, ib.diff30); end
      end
    end
  endtask

  task automatic test_overrun;
    logic [3*PW-1:0] e;
    @(negedge clk);
    start_a(19'h11111, 19'h22222, 19'h7FFFF, 19'h00001);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++; if (ia.ovr !== (c >= 4)) begin errors++; $display("FAIL ovr_rise cycle %0d got %b", c, ia.ovr); end
      ia.ph_valid = (c == 3);
      if (c == 3) {ia.ph0, ia.ph1, ia.ph2, ia.ph3} = {4{19'h55555}};
      if (c == 7) begin
        e = qa.size() != 0 ? qa.pop_front() : 'x;
        checks++; if (ia.diff_valid !== 1'b1) begin errors++; $display("FAIL ovr_diff_valid got %b exp 1", ia.diff_valid); end
        checks++; if ({ia.diff10, ia.diff20, ia.diff30} !== e) begin errors++; $display("FAIL ovr_first_frame got %h %h %h exp %h", ia.diff10, ia.diff20, ia.diff30, e); end
      end
    end
    checks++; if (ia.ph_ready !== 1'b1) begin errors++; $display("FAIL ovr_ph_ready got %b exp 1", ia.ph_ready); end
    start_a(19'h2D000, 19'h2D000, 19'h2D000, 19'h2D000);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      ia.ph_valid = 1'b0;
    end
    e = qa.size() != 0 ? qa.pop_front() : 'x;
    checks++; if (ia.diff_valid !== 1'b1) begin errors++; $display("FAIL ovr2_diff_valid got %b exp 1", ia.diff_valid); end
    checks++; if ({ia.diff10, ia.diff20, ia.diff30} !== e || e !== '0) begin errors++; $display("FAIL ovr2_zero got %h %h %h exp 0", ia.diff10, ia.diff20, ia.diff30); end
    checks++; if (ia.ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", ia.ovr); end
  endtask

  task automatic test_reset_mid;
    logic [3*PW-1:0] e;
    int n;
    @(negedge clk);
    start_a(19'($urandom), 19'($urandom), 19'($urandom), 19'($urandom));
    n = 0;
    do begin @(negedge clk); ia.ph_valid = 1'b0; n++; end while (ia.diff_valid !== 1'b1 && n < 20);
    e = qa.size() != 0 ? qa.pop_front() : 'x;
    checks++; if ({ia.diff10, ia.diff20, ia.diff30} !== e) begin errors++; $display("FAIL rmid_pre got %h %h %h exp %h", ia.diff10, ia.diff20, ia.diff30, e); end
    @(negedge clk);
    start_a(19'h00123, 19'h04567, 19'h089AB, 19'h0CDEF);
    @(negedge clk);
    ia.ph_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    qa.delete();
    checks++; if ({ia.ph_ready, ia.pd_data_rdy, ia.diff_valid, ia.ovr} !== 4'b1000) begin errors++; $display("FAIL rmid_flags got rdy=%b pd=%b dv=%b ovr=%b exp 1000", ia.ph_ready, ia.pd_data_rdy, ia.diff_valid, ia.ovr); end
    checks++; if ({ia.pd_phase1, ia.pd_phase2} !== '0) begin errors++; $display("FAIL rmid_pd_phase got %h %h exp 0", ia.pd_phase1, ia.pd_phase2); end
    checks++; if ({ia.diff10, ia.diff20, ia.diff30} !== '0) begin errors++; $display("FAIL rmid_diffs got %h %h %h exp 0", ia.diff10, ia.diff20, ia.diff30); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 2) reset = 1'b0;
      checks++; if (ia.diff_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_valid step %0d got %b exp 0", c, ia.diff_valid); end
    end
    start_a(19'($urandom), 19'($urandom), 19'($urandom), 19'($urandom));
    n = 0;
    do begin @(negedge clk); ia.ph_valid = 1'b0; n++; end while (ia.diff_valid !== 1'b1 && n < 20);
    checks++; if (n !== 7) begin errors++; $display("FAIL rmid_fresh_latency got %0d exp 7", n); end
    e = qa.size() != 0 ? qa.pop_front() : 'x;
    checks++; if ({ia.diff10, ia.diff20, ia.diff30} !== e) begin errors++; $display("FAIL rmid_fresh got %h %h %h exp %h", ia.diff10, ia.diff20, ia.diff30, e); end
  endtask

  task automatic test_back_to_back;
    logic [3*PW-1:0] e;
    logic [PW-1:0] r[4];
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      checks++; if (ia.ph_ready !== (k % 8 == 0)) begin errors++; $display("FAIL b2b_ph_ready cycle %0d got %b", k, ia.ph_ready); end
      checks++; if (ia.ovr !== (k >= 2)) begin errors++; $display("FAIL b2b_ovr cycle %0d got %b", k, ia.ovr); end
      checks++; if (ia.diff_valid !== (k % 8 == 7)) begin errors++; $display("FAIL b2b_diff_valid cycle %0d got %b", k, ia.diff_valid); end
      if (k % 8 == 7) begin
        e = qa.size() != 0 ? qa.pop_front() : 'x;
        checks++; if ({ia.diff10, ia.diff20, ia.diff30} !== e) begin errors++; $display("FAIL b2b_sb cycle %0d got %h %h %h exp %h", k, ia.diff10, ia.diff20, ia.diff30, e); end
      end
      if (k < 32) begin
        for (int i = 0; i < 4; i++) r[i] = 19'($urandom);
        if (k % 8 == 0) start_a(r[0], r[1], r[2], r[3]);
        else {ia.ph0, ia.ph1, ia.ph2, ia.ph3, ia.ph_valid} = {r[0], r[1], r[2], r[3], 1'b1};
      end else ia.ph_valid = 1'b0;
    end
    checks++; if (qa.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d pending exp 0", qa.size()); end
  endtask

  initial begin
    {ia.ph_valid, ia.ph0, ia.ph1, ia.ph2, ia.ph3} = '0;
    {ib.ph_valid, ib.ph0, ib.ph1, ib.ph2, ib.ph3} = '0;
    test_reset();
    test_basic();
    test_latency();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule
